pipeline_piso: RTL
==================

# pipeline_piso

Parallel-in/serial-out word serializer: the read-side counterpart of the team's serial-in/parallel-out pipeline shift registers. It captures a full array of `NUM_WORDS` words in one cycle and presents them one word per cycle, lowest index first, on a valid/ready stream. In the OPL3 datapath it takes per-channel sample vectors and feeds them to the time-multiplexed mixer and DAC-side logic with backpressure.

## Interface
- `DATA_WIDTH`, 16: width of one word.
- `NUM_WORDS`, 18: words per load; must be >= 2.
- `POR_VALUE`, 0: power-on and reset value of the word storage and `out_data`.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load_valid` input 1: `load_data` is valid.
- `load_ready` output 1: block accepts a load this cycle.
- `load_data` input `[NUM_WORDS-1:0][DATA_WIDTH-1:0]`: parallel word array.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: downstream accepts a word.
- `out_data` output `DATA_WIDTH`: current word.
- `out_index` output `$clog2(NUM_WORDS)`: index of the current word within the load.
- `out_last` output 1: the current word is index `NUM_WORDS-1`.

## Operation
- **Load handshake.** A load fires when `load_valid && load_ready`. On that edge, all `NUM_WORDS` words are registered, the index is set to 0, and the block enters SHIFT. `load_data` is sampled only on the firing edge.
- **Output handshake.** A word transfers when `out_valid && out_ready`.
- **States.**
  - IDLE: `load_ready=1`, `out_valid=0`. A load moves the block to SHIFT.
  - SHIFT: `out_valid=1`, `out_data=word[index]`. On each transfer the index increments.
  - Transfer of the last word with no simultaneous load: go to IDLE.
  - Transfer of the last word with a simultaneous load: stay in SHIFT, index goes to 0, and the new words are presented next cycle. This gives back-to-back loads with no bubble.
- **`load_ready` in SHIFT.** Equals `out_ready && index==NUM_WORDS-1`. It is combinational from `out_ready`, with no combinational path from `load_valid`.
- **Backpressure.** While `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable.
- **`out_last`.** Equals `out_valid && index==NUM_WORDS-1`.
- **`out_index`.** Increments by 1 per transfer and never exceeds `NUM_WORDS-1`. No wrap occurs except by reload to 0.
- **Outputs in IDLE.** `out_data` holds its last presented value (or `POR_VALUE` after reset). `out_index` is 0. Downstream must ignore both when `out_valid=0`.
- **Reset.** Applies in any state, including mid-SHIFT. The remaining words are discarded and the block returns to IDLE.
- **Power-on.** Storage and output registers are initialised to `POR_VALUE`, so the block is correct even before the first reset.

## Timing
- Reset values:
  - `out_valid=0`, `load_ready=1`, `out_index=0`, `out_last=0`.
  - `out_data=POR_VALUE`; storage is `POR_VALUE`.
  - State is IDLE.
- Load-to-first-word latency: 1 cycle. A load firing at edge N gives `out_valid=1` with word 0 from edge N.
- Throughput:
  - With `out_ready` held high, one load drains in exactly `NUM_WORDS` cycles.
  - Continuous back-to-back loads sustain one word per cycle.
- Words are emitted strictly in order 0..`NUM_WORDS-1`, with no drop or duplication under any `out_ready` pattern.
- `load_valid` asserted while `load_ready=0` has no effect; the upstream holds it.

## Test plan
- **Single load, free-running output.** After reset, load words 0x0000..0x0011 (`NUM_WORDS=18`) with `out_ready=1`. Required:
  - 18 consecutive transfers with `out_data==out_index`.
  - `out_last` only on 0x0011.
  - `out_valid=0` on the following cycle.
- **Backpressure.** Same load, with `out_ready` toggling 1,0,0,1,... Required:
  - Every stalled cycle holds `out_data`, `out_index` and `out_last` unchanged.
  - All 18 words arrive in order.
- **Back-to-back loads.** Load A (0x1000+i), then hold `load_valid=1` with B (0x2000+i) and `out_ready=1`. Required:
  - `load_ready=1` only on A's last cycle.
  - B's word 0 follows A's word 17 with no idle cycle.
  - 36 contiguous transfers.
- **Load ignored while busy.** Pulse `load_valid` with C during A's index 5. Required:
  - C is not accepted.
  - A's words 6..17 are unchanged.
- **Reset mid-operation.** Assert `reset` at index 9 of a load. Required:
  - The next cycle shows `out_valid=0`, `out_index=0`, `load_ready=1`, `out_data=POR_VALUE`.
  - A following load emits from index 0.
- **Power-on without reset.** With `POR_VALUE=0x5A5A` and no reset, load at cycle 0. Required:
  - `out_data=0x5A5A` before the load.
  - Correct serialization after the load.

Source files
------------

// File: rtl/pipeline_piso.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_piso
// Brief    : Parallel-in/serial-out word serializer on a valid/ready stream.
//            Captures NUM_WORDS words in one cycle, emits them lowest index first.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_piso #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_WORDS  = 18,
    parameter logic [DATA_WIDTH-1:0] POR_VALUE  = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] load_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [$clog2(NUM_WORDS)-1:0]         out_index,
    output logic                                 out_last
);

    localparam int                 c_IDX_W    = $clog2(NUM_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    // Declaration initialisers give the power-on state without needing a reset.
    logic [0:0]                          r_state = c_S_IDLE;
    logic [c_IDX_W-1:0]                  r_index = '0;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_words = {NUM_WORDS{POR_VALUE}};

    logic [0:0]         w_state_next;
    logic [c_IDX_W-1:0] w_index_next;
    logic               w_at_last;
    logic               w_load_ready;
    logic               w_load_fire;
    logic               w_out_fire;

    always_comb begin
        w_at_last    = (r_index == c_LAST_IDX);
        w_load_ready = (r_state == c_S_IDLE) | (out_ready & w_at_last);
        w_load_fire  = load_valid & w_load_ready;
        w_out_fire   = (r_state == c_S_SHIFT) & out_ready;
        w_state_next = r_state;
        w_index_next = r_index;
        if (w_load_fire) begin
            w_state_next = c_S_SHIFT;
            w_index_next = '0;
        end else if (w_out_fire) begin
            if (w_at_last) begin
                w_state_next = c_S_IDLE;
                w_index_next = '0;
            end else begin
                w_index_next = r_index + c_IDX_W'(1);
            end
        end
    end

    // Words shift down so the presented word is always slot 0; the final
    // transfer does not shift, leaving the last word visible while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_index <= '0;
            r_words <= {NUM_WORDS{POR_VALUE}};
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            if (w_load_fire) begin
                r_words <= load_data;
            end else if (w_out_fire && !w_at_last) begin
                r_words <= {r_words[NUM_WORDS-1], r_words[NUM_WORDS-1:1]};
            end
        end
    end

    assign load_ready = w_load_ready;
    assign out_valid  = (r_state == c_S_SHIFT);
    assign out_data   = r_words[0];
    assign out_index  = r_index;
    assign out_last   = (r_state == c_S_SHIFT) & w_at_last;

endmodule
`default_nettype wire
